pipeline_debug_streamer: RTL and testbench
==========================================

# pipeline_debug_streamer

Debug/control stage directly downstream of the five-stage MIPS pipeline. It gates pipeline advancement through a clock-enable (`pipe_en`) in run, single-step and halt modes, and counts advanced cycles. After every step, halt or dump it snapshots a set of pipeline observation words and streams them as a checksummed byte frame over a valid/ready byte interface, such as a UART transmitter.

## Interface
Parameters:
- `NWORDS`, default 4: number of 32-bit observation words captured per frame (1..16).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_data`  in  8  command byte.
- `cmd_valid`  in  1  command byte present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `snap_in`  in  32*NWORDS  observation words; word i on bits [32i+31:32i] (e.g. PC_sumado_IF, instruction_ID, ALU_result_MEM, Write_Data).
- `pipe_en`  out  1  registered pipeline clock-enable; pipeline advances on edges where it is 1.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  frame byte present.
- `tx_ready`  in  1  sink accepts; a byte transfers when `tx_valid & tx_ready` at a rising edge.
- `busy`  out  1  high in any state other than IDLE and RUN.

## Operation
- Commands:
  - 0x52 `R`: run.
  - 0x53 `S`: step.
  - 0x48 `H`: halt.
  - 0x44 `D`: dump.
  - Any other code is accepted and dropped.
- States: IDLE, RUN, STEP, CAPTURE, SEND_HDR, SEND_DATA, SEND_CHK.
- `cmd_ready` = 1 in IDLE and RUN only, 0 otherwise.
- IDLE: `pipe_en`=0.
  - `R` → RUN.
  - `S` → STEP.
  - `D` → CAPTURE.
  - `H` is ignored.
- RUN: `pipe_en`=1.
  - `H` → CAPTURE.
  - `R`, `S` and `D` are accepted and ignored.
- STEP: `pipe_en`=1 for exactly one cycle, then → CAPTURE.
- CAPTURE: one cycle with `pipe_en`=0. At its closing edge:
  - `snap_in` is loaded into the snapshot register.
  - The cycle counter is latched.
  - Next state is SEND_HDR.
- Frame, in byte order:
  - 0xA5 header.
  - Latched cycle count, 4 bytes, little-endian.
  - Word 0..NWORDS-1, 4 bytes each, little-endian.
  - Checksum byte.
- Checksum = XOR of all bytes after the header.
- Frame length = 6 + 4·NWORDS bytes.
- After the checksum transfers → IDLE.
- Cycle counter: 32-bit, increments on every edge where `pipe_en`=1. It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.
- Byte index counter sized for 4·NWORDS+4 entries.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE.
  - `pipe_en`=0.
  - `tx_valid`=0, `tx_data`=0x00.
  - `busy`=0.
  - `cmd_ready`=1.
  - Cycle counter 0, snapshot 0, checksum accumulator 0.
- Reset asserted mid-frame aborts the frame. `tx_valid` drops without completing the handshake.
- Step, `S` accepted at edge E0:
  - `pipe_en`=1 during E0→E1.
  - CAPTURE during E1→E2.
  - Snapshot loaded at E2; header presented with `tx_valid`=1 from E2.
- Dump, `D` accepted at E0: snapshot loaded at E1, header from E1. `pipe_en` stays 0 and the count is unchanged.
- Halt, `H` accepted at E0 in RUN:
  - The pipeline still advances at E0, which is counted.
  - `pipe_en`=0 from E0.
  - Snapshot loaded at E1.
- Byte sink handshake:
  - `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
  - The next byte is presented the cycle after a transfer. With `tx_ready` held at 1, one byte transfers per cycle.
  - `tx_valid` never deasserts mid-frame except on reset.
- Back-to-back: the first cycle after the checksum transfer is IDLE with `cmd_ready`=1. No command is lost if `cmd_valid` is held.
- `snap_in` changes after the capture edge do not affect the frame in flight.

## Test plan
- Reset, then dump with NWORDS=4 and `snap_in` = {0x44444444, 0x33333333, 0x22222222, 0x11111111}, `tx_ready`=1:
  - Bytes: A5, 00 00 00 00, 11×4, 22×4, 33×4, 44×4, checksum 0x00.
  - 22 bytes total, `busy` high throughout.
- Step three times with `snap_in` tracking the cycle number: each frame carries counts 1, 2, 3, and `pipe_en` is high for exactly one cycle per step.
- Run for 10 cycles, then halt:
  - Count field = 11 (the halt edge is included).
  - `pipe_en` is 0 after the halt edge.
  - `S` sent during RUN has no effect.
- Throttle `tx_ready` to 1 every third cycle during a dump:
  - `tx_data` is stable while stalled.
  - Byte order and checksum are unchanged.
  - `cmd_ready` is 0 until the frame ends.
- Assert `reset` during the 7th byte of a frame:
  - `tx_valid` and `pipe_en` are 0 immediately.
  - A following `D` emits a count of 0.
- Force the counter to 0xFFFFFFFE, step twice: frames carry counts 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/pipeline_debug_streamer.sv
// Debug/control stage behind the MIPS pipeline: gates pipe_en for run/step/halt
// and streams a checksummed snapshot frame (A5, count, words, XOR) over valid/ready.
module pipeline_debug_streamer #(
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [32*NWORDS-1:0]  snap_in,
  output logic                  pipe_en,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  localparam int NDATA = 4 * NWORDS + 4;
  localparam int IDXW  = $clog2(NDATA);

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_CAPTURE,
    S_SEND_HDR,
    S_SEND_DATA,
    S_SEND_CHK
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [31:0]               cycle_count;
  logic [31:0]               count_latch;
  logic [32*NWORDS-1:0]      snap_reg;
  logic [7:0]                chk_acc;
  logic [IDXW-1:0]           byte_idx;
  logic [32*(NWORDS+1)-1:0]  data_vec;
  logic [7:0]                cur_byte;
  logic                      cmd_accept;
  logic                      tx_fire;

  // Payload bytes after the header: latched count first, then the words, all little-endian.
  assign data_vec   = {snap_reg, count_latch};
  assign cur_byte   = data_vec[{byte_idx, 3'b000} +: 8];
  assign cmd_accept = cmd_valid & cmd_ready;
  assign tx_fire    = tx_valid & tx_ready;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (cmd_accept) begin
          case (cmd_data)
            CMD_RUN:  next_state = S_RUN;
            CMD_STEP: next_state = S_STEP;
            CMD_DUMP: next_state = S_CAPTURE;
            default:  next_state = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (cmd_accept && (cmd_data == CMD_HALT)) next_state = S_CAPTURE;
      end
      S_STEP:     next_state = S_CAPTURE;
      S_CAPTURE:  next_state = S_SEND_HDR;
      S_SEND_HDR: begin
        if (tx_fire) next_state = S_SEND_DATA;
      end
      S_SEND_DATA: begin
        if (tx_fire && (byte_idx == IDXW'(NDATA - 1))) next_state = S_SEND_CHK;
      end
      S_SEND_CHK: begin
        if (tx_fire) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      S_IDLE, S_RUN: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_SEND_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
      end
      S_SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
      end
      S_SEND_CHK: begin
        tx_valid = 1'b1;
        tx_data  = chk_acc;
      end
      default: ;
    endcase
  end

  // pipe_en is registered from the next state so it lines up exactly with RUN/STEP residency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pipe_en <= 1'b0;
    end else begin
      state   <= next_state;
      pipe_en <= (next_state == S_RUN) || (next_state == S_STEP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (pipe_en) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // The capture cycle freezes the frame contents; later snap_in activity is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_reg    <= '0;
      count_latch <= 32'd0;
      chk_acc     <= 8'h00;
      byte_idx    <= '0;
    end else if (state == S_CAPTURE) begin
      snap_reg    <= snap_in;
      count_latch <= cycle_count;
      chk_acc     <= 8'h00;
      byte_idx    <= '0;
    end else if ((state == S_SEND_DATA) && tx_fire) begin
      chk_acc  <= chk_acc ^ cur_byte;
      byte_idx <= byte_idx + IDXW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_debug_streamer.sv
// Directed-plus-random bench for pipeline_debug_streamer; frames are checked
// against a byte-list model built from the latched count and snapshot words.
module tb_pipeline_debug_streamer;

  localparam int NW = 4;

  logic              clk;
  logic              reset;
  logic [7:0]        cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [32*NW-1:0]  snap_in;
  logic              pipe_en;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  int vectors;
  int miscompares;

  logic [31:0] model_count;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  pipeline_debug_streamer #(.NWORDS(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .snap_in   (snap_in),
    .pipe_en   (pipe_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame from first principles: header, count, words, XOR of payload.
  function automatic void buildFrame(input logic [31:0] cnt, input logic [32*NW-1:0] snap);
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  chk;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    chk = 8'h00;
    for (int k = 0; k <= NW; k++) begin
      w = (k == 0) ? cnt : snap[32*(k-1) +: 32];
      for (int j = 0; j < 4; j++) begin
        b = 8'((w >> (8 * j)) & 32'hFF);
        exp_q.push_back(b);
        chk = chk ^ b;
      end
    end
    exp_q.push_back(chk);
  endfunction

  function automatic logic [32*NW-1:0] randSnap();
    logic [32*NW-1:0] s;
    for (int k = 0; k < NW; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  task automatic applyStimulus(input logic [7:0] c);
    checkOutput("cmd_ready before cmd", 32'(cmd_ready), 32'd1);
    cmd_data  = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("reset pipe_en", 32'(pipe_en), 32'd0);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_count = 32'd0;
  endtask

  // mode 0: always ready, 1: ready every third cycle, 2: random ready.
  task automatic collectFrame(input int mode, input int stop_at, input logic [31:0] cnt,
                              input logic [32*NW-1:0] snap, output int pipe_hi);
    logic       stalled;
    logic       started;
    logic [7:0] held;
    int         cyc;
    buildFrame(cnt, snap);
    got_q.delete();
    stalled = 1'b0;
    started = 1'b0;
    held    = 8'h00;
    cyc     = 0;
    pipe_hi = 0;
    while (got_q.size() < stop_at && cyc < 1000) begin
      pipe_hi += int'(pipe_en);
      if (started) checkOutput("tx_valid held mid-frame", 32'(tx_valid), 32'd1);
      if (stalled) checkOutput("tx_data stable in stall", 32'(tx_data), 32'(held));
      if (tx_valid) begin
        started = 1'b1;
        checkOutput("busy in frame", 32'(busy), 32'd1);
        checkOutput("cmd_ready in frame", 32'(cmd_ready), 32'd0);
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((cyc % 3) == 2);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        stalled = 1'b0;
        snap_in = randSnap();
      end else if (tx_valid) begin
        stalled = 1'b1;
        held    = tx_data;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    if (got_q.size() < stop_at)
      checkOutput("frame timeout bytes", 32'(got_q.size()), 32'(stop_at));
    for (int i = 0; i < got_q.size(); i++)
      checkOutput($sformatf("frame byte %0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    if (stop_at == exp_q.size()) begin
      checkOutput("post-frame cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("post-frame busy", 32'(busy), 32'd0);
      checkOutput("post-frame tx_valid", 32'(tx_valid), 32'd0);
    end
  endtask

  initial begin
    logic [32*NW-1:0] snap;
    logic [7:0]       junk;
    int               ph;
    int               sel;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    cmd_data    = 8'h00;
    cmd_valid   = 1'b0;
    tx_ready    = 1'b0;
    snap_in     = '0;
    model_count = 32'd0;

    doReset();

    // Fixed-pattern dump: payload XOR cancels to 0x00, 22 bytes.
    snap    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    snap_in = snap;
    applyStimulus(8'h44);
    collectFrame(0, 6 + 4 * NW, model_count, snap, ph);
    checkOutput("dump frame length", 32'(got_q.size()), 32'd22);
    checkOutput("dump checksum", 32'(got_q[21]), 32'h00);
    checkOutput("dump pipe_en cycles", 32'(ph), 32'd0);

    // Three single steps; snap word 0 tracks the expected cycle number.
    for (int s = 0; s < 3; s++) begin
      model_count = model_count + 32'd1;
      snap = randSnap();
      snap[31:0] = model_count;
      snap_in = snap;
      applyStimulus(8'h53);
      collectFrame(0, 6 + 4 * NW, model_count, snap, ph);
      checkOutput("step pipe_en cycles", 32'(ph), 32'd1);
      checkOutput("step count byte0", 32'(got_q[1]), 32'(s + 1));
    end

    // Run for ten cycles (with an ignored S), then halt: halt edge is counted.
    doReset();
    snap = randSnap();
    snap_in = snap;
    applyStimulus(8'h52);
    for (int i = 0; i < 10; i++) begin
      checkOutput("run pipe_en", 32'(pipe_en), 32'd1);
      checkOutput("run busy", 32'(busy), 32'd0);
      if (i == 4) applyStimulus(8'h53);
      else @(negedge clk);
    end
    applyStimulus(8'h48);
    checkOutput("halt pipe_en", 32'(pipe_en), 32'd0);
    model_count = 32'd11;
    collectFrame(0, 6 + 4 * NW, 32'd11, snap, ph);
    checkOutput("halt pipe_en cycles", 32'(ph), 32'd0);

    // Throttled dump, ready every third cycle.
    snap = randSnap();
    snap_in = snap;
    applyStimulus(8'h44);
    collectFrame(1, 6 + 4 * NW, model_count, snap, ph);

    // Unknown codes and H in IDLE are dropped.
    for (int i = 0; i < 4; i++) begin
      junk = 8'($urandom_range(0, 255));
      while (junk == 8'h52 || junk == 8'h53 || junk == 8'h44) junk = 8'($urandom_range(0, 255));
      if (i == 0) junk = 8'h48;
      applyStimulus(junk);
      checkOutput("dropped cmd busy", 32'(busy), 32'd0);
      checkOutput("dropped cmd pipe_en", 32'(pipe_en), 32'd0);
    end

    // Random mix of steps and dumps with random sink back-pressure.
    for (int i = 0; i < 6; i++) begin
      sel = $urandom_range(0, 1);
      snap = randSnap();
      snap_in = snap;
      if (sel == 1) model_count = model_count + 32'd1;
      applyStimulus(sel == 1 ? 8'h53 : 8'h44);
      collectFrame(2, 6 + 4 * NW, model_count, snap, ph);
      checkOutput("random pipe_en cycles", 32'(ph), 32'(sel));
    end

    // Reset while the 7th byte is presented aborts the frame and clears the counter.
    snap = randSnap();
    snap_in = snap;
    applyStimulus(8'h44);
    collectFrame(0, 6, model_count, snap, ph);
    checkOutput("7th byte presented", 32'(tx_valid), 32'd1);
    doReset();
    snap = randSnap();
    snap_in = snap;
    applyStimulus(8'h44);
    collectFrame(0, 6 + 4 * NW, 32'd0, snap, ph);

    // Counter wrap across two steps.
    force dut.cycle_count = 32'hFFFFFFFE;
    @(negedge clk);
    release dut.cycle_count;
    model_count = 32'hFFFFFFFE;
    for (int s = 0; s < 2; s++) begin
      model_count = model_count + 32'd1;
      snap = randSnap();
      snap_in = snap;
      applyStimulus(8'h53);
      collectFrame(0, 6 + 4 * NW, model_count, snap, ph);
    end
    checkOutput("wrap count byte3", 32'(got_q[4]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
